// File: rtl/result_display_seq.sv
// Display sequencer: snapshots four result words on load and steps every lane's nibbles MSB-first
// to the 7-segment decoders, then parks on nibble 0. Define DISP_BLANK_EN for leading-zero blanking.
module result_display_seq #(
    parameter int RES_W       = 16,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [RES_W-1:0]           res0,
    input  logic [RES_W-1:0]           res1,
    input  logic [RES_W-1:0]           res2,
    input  logic [RES_W-1:0]           res3,
    input  logic                       adv,
    output logic [3:0]                 nib0,
    output logic [3:0]                 nib1,
    output logic [3:0]                 nib2,
    output logic [3:0]                 nib3,
    output logic [3:0]                 blank,
    output logic [$clog2(RES_W/4)-1:0] digit_idx,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int DIGITS = RES_W / 4;
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int HC_W   = $clog2(HOLD_CYCLES);
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(DIGITS - 1);
    localparam logic [HC_W-1:0]  HOLD_LAST  = HC_W'(HOLD_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    logic [0:0]       state;
    logic [HC_W-1:0]  hcnt;
    logic [RES_W-1:0] snap [4];
    logic             step;
    logic [IDX_W+1:0] bit_base;

    // A manual advance and a coincident timeout collapse into one step.
    assign step     = adv || (hcnt == HOLD_LAST);
    assign bit_base = {digit_idx, 2'b00};
    assign busy     = (state == SHOW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hcnt       <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) snap[i] <= '0;
        end else begin
            frame_done <= 1'b0;
            if (load) begin
                snap[0]   <= res0;
                snap[1]   <= res1;
                snap[2]   <= res2;
                snap[3]   <= res3;
                digit_idx <= LAST_DIGIT;
                hcnt      <= '0;
                state     <= SHOW;
            end else if (state == SHOW) begin
                if (step) begin
                    hcnt <= '0;
                    if (digit_idx != '0) begin
                        digit_idx <= digit_idx - 1'b1;
                    end else begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

    // Nibbles come only from the snapshot, never straight from res*.
    assign nib0 = snap[0][bit_base +: 4];
    assign nib1 = snap[1][bit_base +: 4];
    assign nib2 = snap[2][bit_base +: 4];
    assign nib3 = snap[3][bit_base +: 4];

`ifdef DISP_BLANK_EN
    // Blank when the current nibble and everything above it is zero; digit 0 always shows.
    always_comb begin
        blank = '0;
        for (int i = 0; i < 4; i++) begin
            blank[i] = (digit_idx != '0) && ((snap[i] >> bit_base) == '0);
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: doc/result_display_seq.md
# result_display_seq

Downstream display sequencer between the matrix multiplier's four result words and the four 7-segment decoders. On a load pulse it snapshots all four results and steps every lane through its nibbles, most significant first, one nibble per hold interval or per manual advance. It then parks on nibble 0, so the idle display still shows each result's low nibble. This block replaces the fixed `[3:0]` tap on each result.

## Interface

Parameters:
- `RES_W`, default 16: result word width; must be a multiple of 4 and at least 8.
- `HOLD_CYCLES`, default 25_000_000: cycles each nibble is shown in SHOW; must be at least 2.
- `DIGITS`, derived as `RES_W/4`: nibbles per result.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `load`, input, 1: one-cycle pulse that captures `res0..res3` and starts a sequence.
- `res0`..`res3`, input, `RES_W` each: result words from the multiplier.
- `adv`, input, 1: one-cycle pulse that advances to the next nibble immediately.
- `nib0`..`nib3`, output, 4 each: current nibble of each snapshot lane, driven to the segment decoders.
- `blank`, output, 4: per-lane blank request (bit i goes with `nibI`).
- `digit_idx`, output, `$clog2(DIGITS)`: index of the nibble currently displayed.
- `busy`, output, 1: high while in SHOW.
- `frame_done`, output, 1: one-cycle pulse when a sequence completes.

## Operation

- State machine has two states: IDLE and SHOW.
- Registered state:
  - `snap0..snap3`, `RES_W` bits each.
  - `digit_idx`.
  - Hold counter `hcnt`, wide enough to hold `HOLD_CYCLES-1`.
- Reset values:
  - State IDLE; `snap*` = 0; `digit_idx` = 0; `hcnt` = 0.
  - `busy` = 0; `frame_done` = 0; `blank` = 0.
  - `nib*` therefore read 0.
- `nibI` = `snapI[4*digit_idx +: 4]`, taken from registered state only; no combinational path from `res*`.
- IDLE:
  - `load` → capture `res0..res3`, set `digit_idx` = `DIGITS-1`, `hcnt` = 0, go to SHOW.
  - `adv` is ignored.
- SHOW: `hcnt` increments every cycle. A step event is `adv`=1 or `hcnt`==`HOLD_CYCLES-1`. On a step event:
  - If `digit_idx` > 0: decrement `digit_idx`, clear `hcnt`.
  - If `digit_idx` == 0: clear `hcnt`, go to IDLE, pulse `frame_done` in the following cycle. `digit_idx` stays 0.
- Priority on the same edge: `load` > `adv` > timeout.
  - `load` in SHOW re-captures and restarts at `DIGITS-1`, with no `frame_done`.
  - `adv` together with a timeout counts as a single step.
- `busy` = 1 exactly while the state is SHOW.
- An asynchronous reset mid-sequence returns every register to its reset value immediately. No `frame_done` is produced.

## Timing

- `load` sampled high at edge N:
  - After edge N, `busy`=1, `digit_idx`=`DIGITS-1`, and `nibI` = `resI[RES_W-1 -: 4]` as sampled at N.
- With no `adv`, each nibble is displayed for exactly `HOLD_CYCLES` cycles.
- Full frame length is `DIGITS*HOLD_CYCLES` cycles:
  - `busy` falls on the final step edge.
  - `frame_done` is high for the one cycle after that edge.
- `adv` at edge M: the new `digit_idx` is visible after edge M, and the next timeout falls `HOLD_CYCLES` cycles later.
- `res*` may change at any time without effect except at a `load` edge.

## Configuration

- Macro: `DISP_BLANK_EN`.
- Defined: leading-zero blanking is enabled.
  - `blank[I]` = 1 when `digit_idx` > 0 and `snapI[RES_W-1 : 4*digit_idx]` == 0 (the current nibble and every nibble above it are zero).
  - `blank[I]` is registered-state-derived and tracks `digit_idx` in the same cycle.
  - Digit 0 is never blanked.
- Undefined: `blank` is constant 0 and no blanking logic is synthesized.
- All other behaviour is identical in both builds.

## Test plan

All scenarios use `RES_W`=16 and `HOLD_CYCLES`=4.

- Reset: hold `rst`=0 with `res*` toggling, then release.
  - `nib*`=0, `busy`=0, `digit_idx`=0, `blank`=0, `frame_done`=0.
- Full frame: `res0`=16'h1234, `load` pulse.
  - `nib0` shows 1, 2, 3, 4, each for 4 cycles.
  - `busy` is high for 16 cycles.
  - `frame_done` pulses once on cycle 17.
  - `nib0` stays 4 afterwards.
- Manual advance: `res1`=16'hABCD, `load`, then `adv` on each of the next 3 cycles.
  - `nib1` shows A, B, C, D on consecutive cycles.
  - One more `adv` ends the frame early with `frame_done`.
- Reload mid-frame: `load` with `res2`=16'h00FF; at `digit_idx`=2 pulse `load` with `res2`=16'h5A00.
  - `digit_idx` returns to 3 and `nib2`=5.
  - No `frame_done` between the two loads.
- Blanking (with `DISP_BLANK_EN`): `res3`=16'h0007, `load`.
  - `blank[3]`=1 for `digit_idx` 3, 2, 1 and 0 at `digit_idx` 0, where `nib3`=7.
  - Without the macro, `blank` stays 0 throughout.
- Async reset mid-frame: assert `rst`=0 at `digit_idx`=2 between clock edges.
  - `busy`, `digit_idx` and `nib*` clear before the next edge.
  - No `frame_done` pulse follows.
